// File: rtl/ahb_test_ram.sv
// AHB-Lite test RAM: a 2^DEPTH_LOG2 x 32-bit word array behind a
// single-subordinate AHB port with programmable wait states and the
// standard two-cycle ERROR response for out-of-range, oversized or
// misaligned transfers.
module ahb_test_ram #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_hready,
  output logic        auto_in_hreadyout,
  input  logic [1:0]  auto_in_htrans,
  input  logic [2:0]  auto_in_hsize,
  input  logic        auto_in_hwrite,
  input  logic [29:0] auto_in_haddr,
  input  logic [31:0] auto_in_hwdata,
  output logic        auto_in_hresp,
  output logic [31:0] auto_in_hrdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  state_t                state;
  state_t                state_next;
  logic [1:0]            wait_cnt;
  logic [DEPTH_LOG2-1:0] dp_index;
  logic [1:0]            dp_lane;
  logic [1:0]            dp_size;
  logic                  dp_write;

  logic [31:0]           mem [WORDS];

  logic                  active;
  logic                  align_ok;
  logic                  range_ok;
  logic                  legal;
  logic                  can_accept;
  logic                  accept_ok;
  logic                  accept_err;
  logic                  commit;
  logic [29:0]           upper_bits;
  logic [3:0]            lane_mask;

  // NONSEQ and SEQ both have htrans[1] set; IDLE/BUSY never open a data phase.
  assign active     = auto_in_hready && auto_in_htrans[1];
  assign upper_bits = auto_in_haddr >> (DEPTH_LOG2 + 2);
  assign range_ok   = (upper_bits == '0);

  // Natural alignment check; sizes above a word are never legal.
  always_comb begin
    align_ok = 1'b0;
    case (auto_in_hsize)
      3'd0:    align_ok = 1'b1;
      3'd1:    align_ok = ~auto_in_haddr[0];
      3'd2:    align_ok = (auto_in_haddr[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

  // A new address phase may only be taken when no data phase is stalling.
  assign legal      = range_ok && align_ok;
  assign can_accept = (state == IDLE) || (state == ERR2) ||
                      ((state == DATA) && (wait_cnt == 2'd0));
  assign accept_ok  = can_accept && active && legal;
  assign accept_err = can_accept && active && !legal;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs; completing states fall through to the accept rules.
  always_comb begin
    state_next        = state;
    auto_in_hreadyout = 1'b1;
    auto_in_hresp     = 1'b0;
    case (state)
      IDLE: ;
      DATA: auto_in_hreadyout = (wait_cnt == 2'd0);
      ERR1: begin
        auto_in_hreadyout = 1'b0;
        auto_in_hresp     = 1'b1;
        state_next        = ERR2;
      end
      ERR2: auto_in_hresp = 1'b1;
      default: state_next = IDLE;
    endcase
    if (can_accept) begin
      if (accept_ok)       state_next = DATA;
      else if (accept_err) state_next = ERR1;
      else                 state_next = IDLE;
    end
  end

  // Wait counter and the captured address-phase info for the data phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= 2'd0;
      dp_index <= '0;
      dp_lane  <= 2'd0;
      dp_size  <= 2'd0;
      dp_write <= 1'b0;
    end else if (accept_ok) begin
      wait_cnt <= 2'(WAIT_STATES);
      dp_index <= auto_in_haddr[DEPTH_LOG2+1:2];
      dp_lane  <= auto_in_haddr[1:0];
      dp_size  <= auto_in_hsize[1:0];
      dp_write <= auto_in_hwrite;
    end else if ((state == DATA) && (wait_cnt != 2'd0)) begin
      wait_cnt <= wait_cnt - 2'd1;
    end
  end

  // Byte-lane enables derived from the registered size and low address bits.
  always_comb begin
    lane_mask = 4'b0000;
    case (dp_size)
      2'd0:    lane_mask = 4'b0001 << dp_lane;
      2'd1:    lane_mask = dp_lane[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // A write lands on the edge that ends its completing cycle, unless reset aborts it.
  assign commit = (state == DATA) && (wait_cnt == 2'd0) && dp_write && !reset;

  // Array update, lane by lane; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) mem[dp_index][8*b +: 8] <= auto_in_hwdata[8*b +: 8];
      end
    end
  end

  assign auto_in_hrdata = ((state == DATA) && !dp_write) ? mem[dp_index] : 32'h0;

endmodule
